// File: rtl/cpu_state_sequencer_if.sv
// rtl/cpu_state_sequencer_if.sv - control/status bundle between the CPU datapath and the state sequencer
//
// Purpose: groups the run-control inputs and state/status outputs of
// cpu_state_sequencer into one interface.
// Optional macro: SINGLE_STEP_EN adds STEP_MODE and STEP.
// Signals:
//   CPU_EN      global run enable (to sequencer)
//   OPCLASS     decoded instruction class, 3 bits (to sequencer)
//   FLAG_Z      ALU zero flag (to sequencer)
//   RAM_ACK     RAM access-complete strobe (to sequencer)
//   RESUME      leave-HALT pulse (to sequencer)
//   STEP_MODE   single-step enable (to sequencer, SINGLE_STEP_EN only)
//   STEP        single-step pulse (to sequencer, SINGLE_STEP_EN only)
//   STATE       current control state, 4 bits (from sequencer)
//   HALTED      high while STATE=HALT (from sequencer)
//   FAULT       high while STATE=FAULT (from sequencer)
//   RETIRE      one-cycle pulse per completed instruction (from sequencer)
//   RETIRE_CNT  16-bit retired-instruction count (from sequencer)
// Modports: master = datapath/environment side, slave = sequencer side.
interface cpu_state_sequencer_if;
  logic        CPU_EN;
  logic [2:0]  OPCLASS;
  logic        FLAG_Z;
  logic        RAM_ACK;
  logic        RESUME;
`ifdef SINGLE_STEP_EN
  logic        STEP_MODE;
  logic        STEP;
`endif
  logic [3:0]  STATE;
  logic        HALTED;
  logic        FAULT;
  logic        RETIRE;
  logic [15:0] RETIRE_CNT;

  modport master (
    output CPU_EN, OPCLASS, FLAG_Z, RAM_ACK, RESUME,
`ifdef SINGLE_STEP_EN
    output STEP_MODE, STEP,
`endif
    input  STATE, HALTED, FAULT, RETIRE, RETIRE_CNT
  );

  modport slave (
    input  CPU_EN, OPCLASS, FLAG_Z, RAM_ACK, RESUME,
`ifdef SINGLE_STEP_EN
    input  STEP_MODE, STEP,
`endif
    output STATE, HALTED, FAULT, RETIRE, RETIRE_CNT
  );
endinterface

// File: rtl/cpu_state_sequencer.sv
// rtl/cpu_state_sequencer.sv - multi-cycle CPU control-state sequencer with RAM wait-state watchdog
//
// Purpose: steps FETCH/PCINC/DECODE and the per-class execute states,
// retires instructions, counts them, and traps to FAULT on illegal opcodes
// or RAM accesses that exceed MAX_WAIT cycles.
// Optional macro: SINGLE_STEP_EN (adds STEP_MODE/STEP and a step latch).
// Parameters:
//   MAX_WAIT              RAM wait-state limit in cycles (1..255)
// Ports:
//   LOGISIM_CLOCK_TREE_0  [4] is the clock, [3:0] unused
//   RESET                 synchronous active-high reset
//   bus                   cpu_state_sequencer_if.slave control/status bundle
module cpu_state_sequencer #(
  parameter int MAX_WAIT = 15
) (
  input  logic [4:0]             LOGISIM_CLOCK_TREE_0,
  input  logic                   RESET,
  cpu_state_sequencer_if.slave   bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_PCINC  = 4'd1,
    S_DECODE = 4'd2,
    S_JUMP   = 4'd3,
    S_LOAD   = 4'd4,
    S_STORE  = 4'd5,
    S_EXEC   = 4'd6,
    S_WB     = 4'd7,
    S_HALT   = 4'd8,
    S_FAULT  = 4'd9
  } state_t;

  localparam logic [8:0] WAIT_LIMIT = 9'(MAX_WAIT);

  logic clk;
  logic unused_clk_bits;
  assign clk             = LOGISIM_CLOCK_TREE_0[4];
  assign unused_clk_bits = ^LOGISIM_CLOCK_TREE_0[3:0];

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] retire_cnt_q, retire_cnt_d;
  logic        retire_q, retire_d;
  logic        halted_q, fault_q;
  logic [8:0]  wait_inc;
  logic        fetch_go;

`ifdef SINGLE_STEP_EN
  logic step_pend_q, step_pend_d;
  // In step mode FETCH advances only on a live STEP or one latched earlier.
  assign fetch_go = !bus.STEP_MODE || bus.STEP || step_pend_q;
`else
  assign fetch_go = 1'b1;
`endif

  // One bit wider than the counter so the limit compare cannot wrap.
  assign wait_inc = {1'b0, wait_q} + 9'd1;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    retire_d = 1'b0;
`ifdef SINGLE_STEP_EN
    step_pend_d = step_pend_q;
`endif
    if (bus.CPU_EN) begin
`ifdef SINGLE_STEP_EN
      if (bus.STEP && (state_q != S_FETCH)) step_pend_d = 1'b1;
`endif
      case (state_q)
        S_FETCH: begin
          if (fetch_go) begin
            state_d = S_PCINC;
`ifdef SINGLE_STEP_EN
            step_pend_d = 1'b0;
`endif
          end
        end
        S_PCINC:  state_d = S_DECODE;
        S_DECODE: begin
          case (bus.OPCLASS)
            3'd0: state_d = S_EXEC;
            3'd1: begin state_d = S_LOAD;  wait_d = 8'd0; end
            3'd2: begin state_d = S_STORE; wait_d = 8'd0; end
            3'd3: state_d = S_JUMP;
            3'd4: begin
              if (bus.FLAG_Z) begin
                state_d = S_JUMP;
              end else begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
              end
            end
            3'd5:    state_d = S_HALT;
            default: state_d = S_FAULT;
          endcase
        end
        S_JUMP: begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end
        // RAM_ACK is checked before the limit so an ack on the last
        // allowed cycle still completes normally.
        S_LOAD: begin
          if (bus.RAM_ACK)              state_d = S_WB;
          else if (wait_inc >= WAIT_LIMIT) state_d = S_FAULT;
          else                          wait_d  = wait_inc[7:0];
        end
        S_STORE: begin
          if (bus.RAM_ACK) begin
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end else if (wait_inc >= WAIT_LIMIT) begin
            state_d = S_FAULT;
          end else begin
            wait_d = wait_inc[7:0];
          end
        end
        S_EXEC: state_d = S_WB;
        S_WB: begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end
        S_HALT:  if (bus.RESUME) state_d = S_FETCH;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_FAULT;
      endcase
    end
  end

  assign retire_cnt_d = retire_d ? retire_cnt_q + 16'd1 : retire_cnt_q;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= S_FETCH;
      wait_q       <= 8'd0;
      retire_cnt_q <= 16'd0;
      retire_q     <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
`ifdef SINGLE_STEP_EN
      step_pend_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      retire_cnt_q <= retire_cnt_d;
      retire_q     <= retire_d;
      // Status flags decode the next state so they line up with STATE.
      halted_q     <= (state_d == S_HALT);
      fault_q      <= (state_d == S_FAULT);
`ifdef SINGLE_STEP_EN
      step_pend_q  <= step_pend_d;
`endif
    end
  end

  assign bus.STATE      = state_q;
  assign bus.HALTED     = halted_q;
  assign bus.FAULT      = fault_q;
  assign bus.RETIRE     = retire_q;
  assign bus.RETIRE_CNT = retire_cnt_q;

endmodule
